// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter datapath and its step sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

    // Shift opcodes understood by the single-step shifter.
    localparam logic [2:0] SH_NOP = 3'b000;
    localparam logic [2:0] SH_LSL = 3'b001;
    localparam logic [2:0] SH_LSR = 3'b010;
    localparam logic [2:0] SH_ASR = 3'b011;
    localparam logic [2:0] SH_ROL = 3'b101;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } seq_state_e;

    // A request that leaves the operand untouched skips the shift loop.
    function automatic logic is_trivial(input logic [2:0] op_i, input logic is_zero_amt);
        return (op_i == SH_NOP) || is_zero_amt;
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Drives the external single-step shifter `amount` times, feeding out back to in; optional abort via SHIFT_SEQ_ABORT_EN.
// Latency: done pulses amount+1 cycles after the accepted start (1 cycle for amount==0 or SH_NOP).
// Backpressure: none; start is only sampled in IDLE, starts while busy are dropped.
module shift_sequencer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic [WIDTH-1:0] sh_in,
    output logic [2:0]       sh_op,
    input  logic [WIDTH-1:0] sh_out,
    input  logic             sh_cout,
    input  logic             sh_overflow
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic; visible result/cout/overflow only move on entry to DONE,
    // so an aborted request leaves the previous outputs intact.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        ovf_acc_d  = ovf_acc_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    acc_d     = operand;
                    cnt_d     = amount;
                    ovf_acc_d = 1'b0;
                    if (is_trivial(op, amount == '0)) begin
                        state_d    = ST_DONE;
                        result_d   = operand;
                        cout_d     = 1'b0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d     = sh_out;
                ovf_acc_d = ovf_acc_q | sh_overflow;
                cnt_d     = cnt_q - AMT_W'(1);
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == AMT_W'(1)) begin
                    state_d    = ST_DONE;
                    result_d   = sh_out;
                    cout_d     = sh_cout;
                    overflow_d = ovf_acc_q | sh_overflow;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            op_q       <= SH_NOP;
            ovf_acc_q  <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ovf_acc_q  <= ovf_acc_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign sh_in    = acc_q;
    assign sh_op    = op_q;

endmodule
